result_reporter: RTL

Drains the per-string match vector produced at the end of a search pass and emits the index of every matched string, lowest first, one per valid/ready handshake. It sits downstream of the result aggregation stage. It snapshots the vector on the controller's completion strobe, so the aggregator can start the next pass immediately. A one-cycle done pulse with the match count closes each report.

---
 rtl/result_pkg.sv | 12 +
 rtl/result_reporter_if.sv | 13 +
 rtl/result_reporter_lsb_priority_enc.sv | 20 ++
 rtl/result_reporter.sv | 104 ++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// Shared types and sizing helpers for the result reporter.
package result_pkg;

  localparam int unsigned total_weights_default = 100;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {StIdle, StScan, StEmit, StDone} state_e;

endpackage

// File: rtl/result_reporter_if.sv
// Valid/ready stream carrying matched string indices out of the reporter.
interface result_reporter_if #(
  parameter int unsigned IDW = result_pkg::idx_width(result_pkg::total_weights_default)
) ();

  logic           match_valid;
  logic [IDW-1:0] match_id;
  logic           out_ready;

  modport master (output match_valid, output match_id, input out_ready);
  modport slave  (input match_valid, input match_id, output out_ready);

endinterface

// File: rtl/result_reporter_lsb_priority_enc.sv
// Combinational lowest-set-bit encoder; index is 0 when no bit is set.
module lsb_priority_enc #(
  parameter int unsigned total_weights = 100,
  parameter int unsigned IDW           = 7
) (
  input  logic [total_weights-1:0] vec,
  output logic [IDW-1:0]           index,
  output logic                     any
);

  always_comb begin
    index = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = int'(total_weights) - 1; i >= 0; i--) begin
      if (vec[i]) index = IDW'(i);
    end
    any = |vec;
  end

endmodule

// File: rtl/result_reporter.sv
// Snapshots a match vector and streams out matched indices lowest first, then pulses done.
// Define RESULT_DROP_CNT_EN to count results_valid strobes ignored while a report is running.
module result_reporter
  import result_pkg::*;
#(
  parameter int unsigned total_weights = total_weights_default,
  parameter int unsigned IDW           = idx_width(total_weights)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [total_weights-1:0] string_results,
  input  logic                     results_valid,
  result_reporter_if.master        match_bus,
  output logic                     busy,
  output logic                     done,
  output logic [IDW:0]             match_count,
  output logic [7:0]               drop_count
);

  state_e                   state;
  logic [total_weights-1:0] pending;
  logic [IDW:0]             count;
  logic [IDW-1:0]           enc_idx;
  logic                     enc_any;

  // pending already has the on-screen index cleared, so one encoder serves SCAN and EMIT.
  lsb_priority_enc #(
    .total_weights(total_weights),
    .IDW          (IDW)
  ) u_enc (
    .vec  (pending),
    .index(enc_idx),
    .any  (enc_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= StIdle;
      pending               <= '0;
      count                 <= '0;
      match_bus.match_valid <= 1'b0;
      match_bus.match_id    <= '0;
      done                  <= 1'b0;
      busy                  <= 1'b0;
      match_count           <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (results_valid) begin
            pending <= string_results;
            count   <= '0;
            busy    <= 1'b1;
            state   <= StScan;
          end
        end
        StScan: begin
          if (!enc_any) begin
            done        <= 1'b1;
            match_count <= count;
            state       <= StDone;
          end else begin
            match_bus.match_id    <= enc_idx;
            match_bus.match_valid <= 1'b1;
            pending[enc_idx]      <= 1'b0;
            state                 <= StEmit;
          end
        end
        StEmit: begin
          if (match_bus.match_valid && match_bus.out_ready) begin
            count <= count + 1'b1;
            if (enc_any) begin
              match_bus.match_id <= enc_idx;
              pending[enc_idx]   <= 1'b0;
            end else begin
              match_bus.match_valid <= 1'b0;
              done                  <= 1'b1;
              match_count           <= count + 1'b1;
              state                 <= StDone;
            end
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef RESULT_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (results_valid && (state != StIdle) && (drop_count != 8'hff)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`else
  assign drop_count = 8'd0;
`endif

endmodule
